pe_group_acc: RTL and testbench

Parametrised successor of the 5-tap row MAC group. Multiplies TAPS ifmap/weight pairs per cycle through a 3-stage pipeline (products, half sums, group sum). Accumulates the group sums of ROWS consecutive valid beats into one window sum, then saturates it and writes it back with a valid strobe and a stretched finish flag. Sits between the ifmap/weight buffers and the ofmap writeback path. One instance serves any kernel of up to TAPS columns and up to 15 rows.

---
 rtl/pe_group_acc_pkg.sv | 27 ++
 rtl/pe_group_acc_mac_tree.sv | 82 ++++++++
 rtl/pe_group_acc.sv | 125 ++++++++++++
 tb/tb_pe_group_acc.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_group_acc_pkg.sv
// Shared constants and helpers for the pe_group_acc MAC group and its adder tree.
package pe_pkg;

  localparam logic RstEnable  = 1'b0;
  localparam logic RstDisable = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Half-sum width for the default 5-lane, 8-bit group.
  localparam int HalfW = 2 * 8 - 1 + clog2(5);

  function automatic logic signed [63:0] sat(input logic signed [63:0] value, input int outW);
    logic signed [63:0] maxV;
    logic signed [63:0] minV;
    maxV = (64'sd1 <<< (outW - 1)) - 64'sd1;
    minV = -(64'sd1 <<< (outW - 1));
    if (value > maxV) return maxV;
    if (value < minV) return minV;
    return value;
  endfunction

endpackage

// File: rtl/pe_group_acc_mac_tree.sv
// Three-stage multiply / half-sum / group-sum pipeline with its valid pipe.
module pe_mac_tree
  import pe_pkg::*;
#(
  parameter int TAPS = 5,
  parameter int DW   = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i_flush,
  input  logic                                i_valid,
  input  logic [TAPS*DW-1:0]                  i_ifmap,
  input  logic [TAPS*DW-1:0]                  i_weight,
  output logic                                o_valid,
  output logic                                o_busy,
  output logic signed [2*DW-1+clog2(TAPS):0]  o_gsum
);

  localparam int PW = 2 * DW - 1;
  localparam int HW = PW + clog2(TAPS);
  localparam int NA = TAPS / 2 + 1;

  logic signed [PW-1:0] w_aExt [TAPS];
  logic signed [PW-1:0] w_bExt [TAPS];
  logic signed [PW-1:0] w_prod [TAPS];
  logic signed [PW-1:0] r_prod [TAPS];
  logic signed [HW-1:0] w_halfA;
  logic signed [HW-1:0] w_halfB;
  logic signed [HW-1:0] r_halfA;
  logic signed [HW-1:0] r_halfB;
  logic signed [HW:0]   r_gsum;
  logic                 r_v1;
  logic                 r_v2;
  logic                 r_v3;

  always_comb begin
    for (int i = 0; i < TAPS; i++) begin
      w_aExt[i] = PW'($signed(i_ifmap[i*DW +: DW]));
      w_bExt[i] = PW'($signed(i_weight[i*DW +: DW]));
      w_prod[i] = w_aExt[i] * w_bExt[i];
    end
  end

  // Half A covers lanes 0..TAPS/2, half B the rest.
  always_comb begin
    w_halfA = '0;
    w_halfB = '0;
    for (int i = 0; i < TAPS; i++) begin
      if (i < NA) w_halfA = w_halfA + HW'(r_prod[i]);
      else        w_halfB = w_halfB + HW'(r_prod[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r_halfA <= '0;
      r_halfB <= '0;
      r_gsum  <= '0;
      for (int i = 0; i < TAPS; i++) r_prod[i] <= '0;
    end else begin
      r_v1 <= i_valid & ~i_flush;
      r_v2 <= r_v1 & ~i_flush;
      r_v3 <= r_v2 & ~i_flush;
      if (i_valid) begin
        for (int i = 0; i < TAPS; i++) r_prod[i] <= w_prod[i];
      end
      if (r_v1) begin
        r_halfA <= w_halfA;
        r_halfB <= w_halfB;
      end
      if (r_v2) r_gsum <= {r_halfA[HW-1], r_halfA} + {r_halfB[HW-1], r_halfB};
    end
  end

  assign o_valid = r_v3;
  assign o_busy  = r_v1 | r_v2 | r_v3;
  assign o_gsum  = r_gsum;

endmodule

// File: rtl/pe_group_acc.sv
// Row-window MAC group: adder tree, window accumulator, saturation and finish flag.
// Optional ReLU clamp on the output when PE_GROUP_RELU_EN is defined.
module pe_group_acc
  import pe_pkg::*;
#(
  parameter int TAPS    = 5,
  parameter int DW      = 8,
  parameter int ACC_W   = 24,
  parameter int OUT_W   = 19,
  parameter int FWB_LEN = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               flush,
  input  logic [3:0]         rows,
  input  logic [TAPS*DW-1:0] ifmap,
  input  logic [TAPS*DW-1:0] weight,
  output logic               busy,
  output logic               out_valid,
  output logic [OUT_W-1:0]   out_sum,
  output logic               finish_wb
);

  localparam int GW = 2 * DW + clog2(TAPS);

  logic                    w_treeValid;
  logic                    w_treeBusy;
  logic signed [GW-1:0]    w_gsum;
  logic signed [ACC_W-1:0] w_accNew;
  logic signed [ACC_W-1:0] r_acc;
  logic [3:0]              r_cnt;
  logic [3:0]              r_rowsQ;
  logic [3:0]              w_rowsEff;
  logic                    w_last;
  logic                    w_emit;
  logic signed [OUT_W-1:0] w_satVal;
  logic signed [OUT_W-1:0] w_outVal;
  logic                    r_outValid;
  logic [OUT_W-1:0]        r_outSum;
  logic                    r_fwb;
  logic [7:0]              r_fwbCnt;

  pe_mac_tree #(
    .TAPS (TAPS),
    .DW   (DW)
  ) u_tree (
    .clk      (clk),
    .rst      (rst),
    .i_flush  (flush),
    .i_valid  (in_valid),
    .i_ifmap  (ifmap),
    .i_weight (weight),
    .o_valid  (w_treeValid),
    .o_busy   (w_treeBusy),
    .o_gsum   (w_gsum)
  );

  // An empty counter means this beat opens a window, so rows is taken live.
  always_comb begin
    w_rowsEff = r_rowsQ;
    w_accNew  = r_acc + ACC_W'(w_gsum);
    if (r_cnt == 4'd0) begin
      w_rowsEff = (rows == 4'd0) ? 4'd1 : rows;
      w_accNew  = ACC_W'(w_gsum);
    end
    w_last   = (r_cnt + 4'd1) == w_rowsEff;
    w_emit   = w_treeValid & w_last & ~flush;
    w_satVal = OUT_W'(sat(64'(w_accNew), OUT_W));
  end

`ifdef PE_GROUP_RELU_EN
  assign w_outVal = w_satVal[OUT_W-1] ? '0 : w_satVal;
`else
  assign w_outVal = w_satVal;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_rowsQ    <= '0;
      r_outValid <= 1'b0;
    end else if (flush) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_outValid <= 1'b0;
    end else begin
      r_outValid <= w_emit;
      if (w_treeValid) begin
        if (w_last) begin
          r_acc <= '0;
          r_cnt <= '0;
        end else begin
          r_acc   <= w_accNew;
          r_cnt   <= r_cnt + 4'd1;
          r_rowsQ <= w_rowsEff;
        end
      end
    end
  end

  // finish_wb survives flush; each new result restarts its hold count.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_outSum <= '0;
      r_fwb    <= 1'b0;
      r_fwbCnt <= '0;
    end else if (w_emit) begin
      r_outSum <= w_outVal;
      r_fwb    <= 1'b1;
      r_fwbCnt <= 8'(FWB_LEN - 1);
    end else if (r_fwbCnt != 8'd0) begin
      r_fwbCnt <= r_fwbCnt - 8'd1;
    end else begin
      r_fwb <= 1'b0;
    end
  end

  assign busy      = w_treeBusy | (r_cnt != 4'd0);
  assign out_valid = r_outValid;
  assign out_sum   = r_outSum;
  assign finish_wb = r_fwb;

endmodule

// File: tb/tb_pe_group_acc.sv
// Scoreboard bench for pe_group_acc: window-sum reference model plus directed and random beats.
module tb_pe_group_acc;

  localparam int TAPS   = 5;
  localparam int DW     = 8;
  localparam int OUT_W  = 19;
  localparam int OutMax = 262143;
  localparam int OutMin = -262144;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                flush;
  logic [3:0]          rows;
  logic [TAPS*DW-1:0]  ifmap;
  logic [TAPS*DW-1:0]  weight;
  logic                busy;
  logic                out_valid;
  logic [OUT_W-1:0]    out_sum;
  logic                finish_wb;

  int     vectors = 0;
  int     miscompares = 0;
  int     expQ[$];
  int     expV;
  int     cyc = 0;
  int     validEdge = -1;
  int     prevValidEdge = -1;
  longint modelAcc = 0;
  int     modelCnt = 0;
  int     modelRows = 1;

  pe_group_acc u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .flush     (flush),
    .rows      (rows),
    .ifmap     (ifmap),
    .weight    (weight),
    .busy      (busy),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .finish_wb (finish_wb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int refOut(input longint acc);
    longint r;
    r = acc;
    if (r > OutMax) r = OutMax;
    else if (r < OutMin) r = OutMin;
`ifdef PE_GROUP_RELU_EN
    if (r < 0) r = 0;
`endif
    return int'(r);
  endfunction

  function automatic int beatSum(input logic [TAPS*DW-1:0] im, input logic [TAPS*DW-1:0] wt);
    int s;
    logic signed [DW-1:0] a;
    logic signed [DW-1:0] b;
    s = 0;
    for (int i = 0; i < TAPS; i++) begin
      a = im[i*DW +: DW];
      b = wt[i*DW +: DW];
      s += int'(a) * int'(b);
    end
    return s;
  endfunction

  function automatic logic [TAPS*DW-1:0] fill(input int v);
    logic [DW-1:0] b;
    b = v[DW-1:0];
    return {TAPS{b}};
  endfunction

  // Reference: group sums of rows consecutive beats, saturated per window.
  task automatic applyStimulus(input logic [TAPS*DW-1:0] im, input logic [TAPS*DW-1:0] wt);
    in_valid = 1'b1;
    ifmap    = im;
    weight   = wt;
    if (modelCnt == 0) begin
      modelRows = (rows == 4'd0) ? 1 : int'(rows);
      modelAcc  = 0;
    end
    modelAcc += beatSum(im, wt);
    modelCnt++;
    if (modelCnt == modelRows) begin
      expQ.push_back(refOut(modelAcc));
      modelCnt = 0;
    end
    @(negedge clk);
  endtask

  task automatic applyValue(input int v);
    logic [TAPS*DW-1:0] im;
    logic [TAPS*DW-1:0] wt;
    im = '0;
    wt = '0;
    im[4*DW +: DW] = v[DW-1:0];
    wt[4*DW +: DW] = 8'd1;
    applyStimulus(im, wt);
  endtask

  task automatic randomBeat();
    logic [TAPS*DW-1:0] im;
    logic [TAPS*DW-1:0] wt;
    int t;
    for (int i = 0; i < TAPS; i++) begin
      im[i*DW +: DW] = 8'($urandom_range(0, 255));
      t = int'($urandom_range(0, 254)) - 127;
      wt[i*DW +: DW] = t[DW-1:0];
    end
    applyStimulus(im, wt);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    in_valid = 1'b0;
    while ((busy || expQ.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) checkOutput("idle_timeout", 1, 0);
  endtask

  always @(negedge clk) begin
    if (rst && out_valid) begin
      prevValidEdge = validEdge;
      validEdge     = cyc;
      checkOutput("finish_wb_with_valid", int'(finish_wb), 1);
      if (expQ.size() == 0) begin
        checkOutput("unexpected_out_valid", 1, 0);
      end else begin
        expV = expQ.pop_front();
        checkOutput("out_sum", int'($signed(out_sum)), expV);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int startCyc;
    int fwbHigh;
    int waited;
    int eff;
    int nBeats;

    rst      = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    rows     = 4'd1;
    ifmap    = '0;
    weight   = '0;
    #2 rst = 1'b0;
    #1;
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_out_sum", int'(out_sum), 0);
    checkOutput("reset_finish_wb", int'(finish_wb), 0);
    checkOutput("reset_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Single rows=1 beat: latency and finish_wb stretch.
    rows     = 4'd1;
    startCyc = cyc;
    applyStimulus(fill(3), fill(2));
    in_valid = 1'b0;
    fwbHigh  = 0;
    repeat (12) begin
      @(negedge clk);
      if (finish_wb) fwbHigh++;
    end
    checkOutput("latency_edges", validEdge - startCyc, 4);
    checkOutput("finish_wb_cycles", fwbHigh, 3);

    // rows=3, two back-to-back windows.
    rows = 4'd3;
    applyValue(10);
    applyValue(-4);
    applyValue(7);
    randomBeat();
    randomBeat();
    randomBeat();
    idle(8);
    checkOutput("back_to_back_gap", validEdge - prevValidEdge, 3);

    // Saturation at both rails.
    rows = 4'd15;
    repeat (15) applyStimulus(fill(127), fill(127));
    repeat (15) applyStimulus(fill(-128), fill(127));
    waitIdle();

    // Flush mid-window, with a colliding beat that must be dropped.
    rows = 4'd4;
    randomBeat();
    randomBeat();
    flush    = 1'b1;
    in_valid = 1'b1;
    ifmap    = fill(9);
    weight   = fill(9);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    modelCnt = 0;
    checkOutput("busy_after_flush", int'(busy), 0);
    checkOutput("out_valid_after_flush", int'(out_valid), 0);
    idle(6);
    rows = 4'd1;
    applyValue(5);
    waitIdle();

    // Asynchronous reset while results are in flight.
    rows = 4'd1;
    randomBeat();
    randomBeat();
    randomBeat();
    in_valid = 1'b0;
    waited   = 0;
    while (!out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("valid_before_reset", int'(out_valid), 1);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_rst_out_valid", int'(out_valid), 0);
    checkOutput("async_rst_out_sum", int'(out_sum), 0);
    checkOutput("async_rst_finish_wb", int'(finish_wb), 0);
    checkOutput("async_rst_busy", int'(busy), 0);
    expQ.delete();
    modelCnt = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rows = 4'd2;
    randomBeat();
    randomBeat();
    waitIdle();

    // Negative single-beat result (clamped to zero when ReLU is built in).
    rows = 4'd1;
    applyValue(-50);
    waitIdle();

    // Randomised windows, rows changed only while idle.
    for (int batch = 0; batch < 12; batch++) begin
      waitIdle();
      rows   = 4'($urandom_range(0, 15));
      eff    = (rows == 4'd0) ? 1 : int'(rows);
      nBeats = eff * int'($urandom_range(1, 3));
      for (int k = 0; k < nBeats; k++) begin
        randomBeat();
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          @(negedge clk);
        end
      end
      in_valid = 1'b0;
    end
    waitIdle();
    idle(4);
    checkOutput("queue_drained", expQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
